// File: rtl/wb_port_arbiter_if.sv
// Writeback request/port bundle between the A/B requesters
// and the register-file write port arbiter.
interface wb_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              init_done;
  logic [ADDR_W-1:0] rd_addr;
  logic              reg_write;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output a_ready, b_ready,
    output init_done, rd_addr,
    output reg_write, wr_data
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  a_ready, b_ready,
    input  init_done, rd_addr,
    input  reg_write, wr_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port owner: zero sweep after reset, then
// A-priority writeback arbitration with a B starvation guard.
module wb_port_arbiter #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  wb_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [SW-1:0]     SMAX = SW'(STARVE_MAX);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [SW-1:0]     starve;
  logic [SW-1:0]     starve_nxt;
  logic              done_q;
  logic              done_nxt;
  logic              we_q;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_nxt;

  logic a_x0;
  logic b_x0;
  logic a_live;
  logic b_live;
  logic force_b;
  logic grant_a;
  logic grant_b;
  logic a_rdy;
  logic b_rdy;

  assign a_x0   = bus.a_rd == '0;
  assign b_x0   = bus.b_rd == '0;
  assign a_live = bus.a_valid && !a_x0;
  assign b_live = bus.b_valid && !b_x0;

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && cnt == LAST)
      state_nxt = S_RUN;
  end

  always_comb begin
    force_b    = 1'b0;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    a_rdy      = 1'b0;
    b_rdy      = 1'b0;
    we_nxt     = 1'b0;
    addr_nxt   = addr_q;
    data_nxt   = data_q;
    cnt_nxt    = cnt;
    starve_nxt = starve;
    done_nxt   = done_q;
    if (!rst) begin
      case (state)
        S_INIT: begin
          we_nxt   = 1'b1;
          addr_nxt = cnt;
          data_nxt = '0;
          cnt_nxt  = cnt + ADDR_W'(1);
          if (cnt == LAST) done_nxt = 1'b1;
        end
        S_RUN: begin
          force_b = a_live && b_live && starve == SMAX;
          grant_a = a_live && !force_b;
          grant_b = b_live && !grant_a;
          // x0 requests retire at once without touching the port
          a_rdy = bus.a_valid && (a_x0 || grant_a);
          b_rdy = bus.b_valid && (b_x0 || grant_b);
          if (grant_a) begin
            we_nxt   = 1'b1;
            addr_nxt = bus.a_rd;
            data_nxt = bus.a_data;
          end else if (grant_b) begin
            we_nxt   = 1'b1;
            addr_nxt = bus.b_rd;
            data_nxt = bus.b_data;
          end
          if (b_live && !grant_b)
            starve_nxt = (starve == SMAX) ? starve
                                          : starve + SW'(1);
          else
            starve_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      starve <= '0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cnt    <= cnt_nxt;
      starve <= starve_nxt;
      done_q <= done_nxt;
      we_q   <= we_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.init_done = done_q;
  assign bus.rd_addr   = addr_q;
  assign bus.reg_write = we_q;
  assign bus.wr_data   = data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed writeback scenarios checked
// against a cycle model plus hand-computed literal expectations.
module tb_wb_port_arbiter;

  localparam int NUM_REGS   = 32;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;

  wb_port_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  wb_port_arbiter #(
    .NUM_REGS(NUM_REGS), .ADDR_W(5),
    .DATA_W(32), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: state of the sweep/arbitration and what the write
  // port must show after the next rising edge.
  bit          m_valid = 0;
  bit          m_init  = 1;
  int          m_sweep = 0;
  int          m_starve = 0;
  logic        e_we   = 0;
  int          e_addr = 0;
  logic [31:0] e_data = 0;
  logic        e_done = 0;

  always @(negedge clk) begin : model
    bit   al, bl, ga, gb;
    logic ea, eb;
    al = bus.a_valid && bus.a_rd != 0;
    bl = bus.b_valid && bus.b_rd != 0;
    ga = 0; gb = 0; ea = 0; eb = 0;
    if (!rst && !m_init) begin
      if (al && bl) begin
        gb = (m_starve >= STARVE_MAX);
        ga = !gb;
      end else begin
        ga = al;
        gb = bl;
      end
      ea = bus.a_valid && (bus.a_rd == 0 || ga);
      eb = bus.b_valid && (bus.b_rd == 0 || gb);
    end
    if (m_valid) begin
      chk("m_reg_write", {31'b0, bus.reg_write}, {31'b0, e_we});
      chk("m_rd_addr", {27'b0, bus.rd_addr}, e_addr);
      chk("m_wr_data", bus.wr_data, e_data);
      chk("m_init_done", {31'b0, bus.init_done}, {31'b0, e_done});
      chk("m_a_ready", {31'b0, bus.a_ready}, {31'b0, ea});
      chk("m_b_ready", {31'b0, bus.b_ready}, {31'b0, eb});
    end
    if (rst) begin
      m_valid  = 1;
      m_init   = 1;
      m_sweep  = 0;
      m_starve = 0;
      e_we = 0; e_addr = 0; e_data = 0; e_done = 0;
    end else if (m_init) begin
      e_we   = 1;
      e_addr = m_sweep;
      e_data = 0;
      if (m_sweep == NUM_REGS - 1) begin
        e_done = 1;
        m_init = 0;
      end
      m_sweep++;
    end else begin
      e_we = ga || gb;
      if (ga) begin
        e_addr = bus.a_rd; e_data = bus.a_data;
      end else if (gb) begin
        e_addr = bus.b_rd; e_data = bus.b_data;
      end
      if (bl && !gb) m_starve = (m_starve < STARVE_MAX)
                                ? m_starve + 1 : STARVE_MAX;
      else           m_starve = 0;
    end
  end

  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
  endtask

  initial begin
    int n_a;
    int n;
    bit got_b;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // T1: sweep
    @(negedge clk);
    chk("t1_pre_we", {31'b0, bus.reg_write}, 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t1_addr", {27'b0, bus.rd_addr}, i);
      chk("t1_we", {31'b0, bus.reg_write}, 1);
      if (i == 30) chk("t1_done_lo", {31'b0, bus.init_done}, 0);
      if (i == 31) chk("t1_done_hi", {31'b0, bus.init_done}, 1);
    end

    // T2: A only
    @(posedge clk); #1;
    bus.a_valid = 1; bus.a_rd = 5; bus.a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t2_a_ready", {31'b0, bus.a_ready}, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("t2_addr", {27'b0, bus.rd_addr}, 5);
    chk("t2_data", bus.wr_data, 32'hDEAD_BEEF);
    chk("t2_we", {31'b0, bus.reg_write}, 1);
    @(negedge clk);
    chk("t2_we_off", {31'b0, bus.reg_write}, 0);

    // T3: starvation guard
    @(posedge clk); #1;
    bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 100;
    bus.b_valid = 1; bus.b_rd = 7; bus.b_data = 32'h777;
    n_a = 0; got_b = 0;
    for (int k = 0; k < 10 && !got_b; k++) begin
      @(negedge clk);
      if (bus.b_ready) begin
        got_b = 1;
        chk("t3_no_a_on_b", {31'b0, bus.a_ready}, 0);
      end else if (bus.a_ready) begin
        n_a++;
      end
      @(posedge clk); #1;
      if (!got_b) bus.a_data = bus.a_data + 1;
    end
    idle_inputs();
    chk("t3_got_b", {31'b0, got_b}, 1);
    chk("t3_a_grants", n_a, 4);
    @(negedge clk);
    chk("t3_b_addr", {27'b0, bus.rd_addr}, 7);
    chk("t3_b_data", bus.wr_data, 32'h777);

    // T4: x0 on A, live B
    @(posedge clk); #1;
    bus.a_valid = 1; bus.a_rd = 0; bus.a_data = 32'h55;
    bus.b_valid = 1; bus.b_rd = 9; bus.b_data = 32'h1234;
    @(negedge clk);
    chk("t4_a_ready", {31'b0, bus.a_ready}, 1);
    chk("t4_b_ready", {31'b0, bus.b_ready}, 1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("t4_addr", {27'b0, bus.rd_addr}, 9);
    chk("t4_data", bus.wr_data, 32'h1234);
    chk("t4_we", {31'b0, bus.reg_write}, 1);

    // T6: idle holds port values
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t6_we", {31'b0, bus.reg_write}, 0);
      chk("t6_addr", {27'b0, bus.rd_addr}, 9);
      chk("t6_data", bus.wr_data, 32'h1234);
    end

    // T5: reset right after a B transfer
    @(posedge clk); #1;
    bus.b_valid = 1; bus.b_rd = 12; bus.b_data = 32'hABC;
    @(negedge clk);
    chk("t5_b_ready", {31'b0, bus.b_ready}, 1);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    chk("t5_b_ready_rst", {31'b0, bus.b_ready}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5_we_off", {31'b0, bus.reg_write}, 0);
    chk("t5_done_lo", {31'b0, bus.init_done}, 0);
    n = 0;
    while (!bus.init_done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("t5_first_addr", {27'b0, bus.rd_addr}, 0);
    end
    chk("t5_sweep_len", n, 32);
    chk("t5_last_addr", {27'b0, bus.rd_addr}, 31);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
